// File: rtl/proc_instr_sequencer_if.sv
// Host/processor-facing bus of the instruction sequencer.
// The slave modport is the sequencer; the master modport is the host plus processor side.
// With SEQ_STEP_MODE_EN defined the bus also carries the step strobe.
interface proc_instr_sequencer_if #(
    parameter int AW = 4
);
    logic          progWe;
    logic [AW-1:0] progAddr;
    logic [16:0]   progData;
    logic [AW:0]   progLen;
    logic          start;
`ifdef SEQ_STEP_MODE_EN
    logic          step;
`endif
    logic          busy;
    logic          done;
    logic [8:0]    func;
    logic [7:0]    dataIn;
    logic [7:0]    dataOut;
    logic [7:0]    result;
    logic          resultValid;

`ifdef SEQ_STEP_MODE_EN
    modport slave  (input  progWe, progAddr, progData, progLen, start, step, dataOut,
                    output busy, done, func, dataIn, result, resultValid);
    modport master (output progWe, progAddr, progData, progLen, start, step, dataOut,
                    input  busy, done, func, dataIn, result, resultValid);
`else
    modport slave  (input  progWe, progAddr, progData, progLen, start, dataOut,
                    output busy, done, func, dataIn, result, resultValid);
    modport master (output progWe, progAddr, progData, progLen, start, dataOut,
                    input  busy, done, func, dataIn, result, resultValid);
`endif
endinterface

// File: rtl/proc_instr_sequencer.sv
// Instruction sequencer: replays a loaded {imm, func} program into the processor,
// one word per cycle, and captures dataOut for every store (op 111) after STORE_LAT cycles.
// Optional feature macro SEQ_STEP_MODE_EN: issue an entry only in cycles where step=1.
module proc_instr_sequencer #(
    parameter int         DEPTH     = 16,
    parameter int         AW        = 4,
    parameter int         STORE_LAT = 2,
    parameter logic [8:0] IDLE_FUNC = 9'b001000000
) (
    input  logic                   clock,
    input  logic                   resetN,
    proc_instr_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_e;

    localparam int          DW      = $clog2(STORE_LAT + 1);
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    state_e               state_q, state_d;
    logic [16:0]          mem_q [DEPTH];
    logic [AW-1:0]        pc_q, pc_d;
    logic [AW:0]          len_q, len_d, len_start;
    logic                 fin_q, fin_d;     // last entry issued, one idle cycle left in ISSUE
    logic [DW-1:0]        drn_q, drn_d;
    logic [8:0]           func_q, func_d;
    logic [7:0]           dataIn_q, dataIn_d;
    logic [7:0]           result_q;
    logic                 busy_q, done_q, rv_q;
    logic [STORE_LAT-1:0] st_pipe_q, st_pipe_d;
    logic                 issue, pc_last;
    logic [16:0]          word;

    assign word      = mem_q[pc_q];
    assign pc_last   = ({1'b0, pc_q} == (len_q - (AW+1)'(1)));
    assign len_start = (bus.progLen > DEPTH_L) ? DEPTH_L : bus.progLen;
`ifdef SEQ_STEP_MODE_EN
    assign issue     = (state_q == S_ISSUE) && !fin_q && bus.step;
`else
    assign issue     = (state_q == S_ISSUE) && !fin_q;
`endif

    // Program memory: host writes land only while idle, so a run never sees its program change.
    always_ff @(posedge clock) begin
        if (bus.progWe && !busy_q)
            mem_q[bus.progAddr] <= bus.progData;
    end

    // FSM state and run bookkeeping registers.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            len_q   <= '0;
            fin_q   <= 1'b0;
            drn_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            len_q   <= len_d;
            fin_q   <= fin_d;
            drn_q   <= drn_d;
        end
    end

    // Next state: ISSUE keeps one trailing idle cycle, then DRAIN runs a fixed STORE_LAT cycles.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        len_d   = len_q;
        fin_d   = fin_q;
        drn_d   = drn_q;
        unique case (state_q)
            S_IDLE: if (bus.start) begin
                len_d   = len_start;
                pc_d    = '0;
                fin_d   = 1'b0;
                drn_d   = '0;
                state_d = (len_start == '0) ? S_DONE : S_ISSUE;
            end
            S_ISSUE: begin
                if (fin_q) begin
                    state_d = S_DRAIN;
                    drn_d   = '0;
                end else if (issue) begin
                    if (pc_last) fin_d = 1'b1;
                    else         pc_d  = pc_q + AW'(1);
                end
            end
            S_DRAIN: begin
                if (drn_q == DW'(STORE_LAT - 1)) state_d = S_DONE;
                else                             drn_d   = drn_q + DW'(1);
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output next-values: issued word or the no-op func, and the store-tracking shift pipe.
    always_comb begin
        func_d    = IDLE_FUNC;
        dataIn_d  = '0;
        st_pipe_d = '0;
        if (issue) begin
            func_d   = word[8:0];
            dataIn_d = word[16:9];
        end
        st_pipe_d[0] = issue && (word[8:6] == 3'b111);
        for (int i = 1; i < STORE_LAT; i++)
            st_pipe_d[i] = st_pipe_q[i-1];
    end

    // Registered outputs; a store leaving the pipe samples the processor's dataOut.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            func_q    <= IDLE_FUNC;
            dataIn_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            st_pipe_q <= '0;
            rv_q      <= 1'b0;
            result_q  <= '0;
        end else begin
            func_q    <= func_d;
            dataIn_q  <= dataIn_d;
            busy_q    <= (state_d != S_IDLE);
            done_q    <= (state_d == S_DONE);
            st_pipe_q <= st_pipe_d;
            rv_q      <= st_pipe_q[STORE_LAT-1];
            if (st_pipe_q[STORE_LAT-1])
                result_q <= bus.dataOut;
        end
    end

    assign bus.func        = func_q;
    assign bus.dataIn      = dataIn_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.result      = result_q;
    assign bus.resultValid = rv_q;
endmodule

// File: tb/tb_proc_instr_sequencer.sv
// Bench for proc_instr_sequencer: a small processor model answers stores on dataOut,
// expected func words and store results are queued per scenario and popped as the run unfolds.
module tb_proc_instr_sequencer;
    localparam logic [8:0] IDLE_F = 9'b001000000;
    localparam int         NOBS   = 64;

    logic clock;
    logic resetN;
    int   errors = 0;
    int   checks = 0;

    proc_instr_sequencer_if #(.AW(4)) bus ();

    proc_instr_sequencer #(.DEPTH(16), .AW(4), .STORE_LAT(2), .IDLE_FUNC(IDLE_F)) dut (
        .clock  (clock),
        .resetN (resetN),
        .bus    (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Processor model: executes the func presented during the previous cycle.
    logic [7:0] regs [8];
    always @(posedge clock) begin
        case (bus.func[8:6])
            3'b000: regs[bus.func[5:3]] <= bus.dataIn;
            3'b001: regs[bus.func[5:3]] <= regs[bus.func[2:0]];
            3'b010: regs[bus.func[5:3]] <= regs[bus.func[5:3]] + regs[bus.func[2:0]];
            3'b011: regs[bus.func[5:3]] <= regs[bus.func[5:3]] - regs[bus.func[2:0]];
            3'b111: bus.dataOut <= regs[bus.func[5:3]];
            default: ;
        endcase
    end

    logic [16:0] prog [16];
    logic [16:0] exp_func [$];
    logic [7:0]  exp_res  [$];
    logic [8:0]  o_func [NOBS];
    logic [7:0]  o_din  [NOBS];
    logic [7:0]  o_res  [NOBS];
    logic        o_rv   [NOBS];
    logic        o_done [NOBS];
    logic        o_busy [NOBS];
    int          step_period = 1;

    task automatic set_main_prog();
        prog[0] = {8'd4, 9'b000_001_000};
        prog[1] = {8'd5, 9'b000_000_000};
        prog[2] = {8'd0, 9'b010_001_000};
        prog[3] = {8'd0, 9'b001_011_001};
        prog[4] = {8'd0, 9'b111_011_000};
    endtask

    task automatic load_prog(input int n);
        for (int i = 0; i < n; i++) begin
            bus.progWe   = 1'b1;
            bus.progAddr = 4'(i);
            bus.progData = prog[i];
            @(posedge clock); #1;
        end
        bus.progWe = 1'b0;
    endtask

    // Pulse start (sampled at edge 0) and record outputs #1 after edges 0..n.
    // inj >= 0: present start plus a program write for the edge after inj.
    task automatic start_run(input int n, input int inj);
        bus.start = 1'b1;
        for (int k = 0; k <= n; k++) begin
            @(posedge clock); #1;
            o_func[k] = bus.func;  o_din[k]  = bus.dataIn; o_res[k]  = bus.result;
            o_rv[k]   = bus.resultValid; o_done[k] = bus.done; o_busy[k] = bus.busy;
            bus.start  = 1'b0;
            bus.progWe = 1'b0;
            if (k == inj) begin
                bus.start    = 1'b1;
                bus.progWe   = 1'b1;
                bus.progAddr = 4'd4;
                bus.progData = {8'd77, 9'b000_011_000};
            end
`ifdef SEQ_STEP_MODE_EN
            bus.step = ((k + 1) % step_period == 0);
`endif
        end
        bus.start  = 1'b0;
        bus.progWe = 1'b0;
`ifdef SEQ_STEP_MODE_EN
        bus.step = 1'b1;
`endif
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        bus.progWe = 1'b0; bus.progAddr = '0; bus.progData = '0;
        bus.progLen = '0;  bus.start = 1'b0;
`ifdef SEQ_STEP_MODE_EN
        bus.step = 1'b1;
`endif
        repeat (2) @(posedge clock); #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", bus.done); end
        checks++; if (bus.func !== IDLE_F) begin errors++; $display("FAIL rst_func got %b want %b", bus.func, IDLE_F); end
        checks++; if (bus.dataIn !== 8'd0) begin errors++; $display("FAIL rst_dataIn got %0d want 0", bus.dataIn); end
        checks++; if (bus.result !== 8'd0) begin errors++; $display("FAIL rst_result got %0d want 0", bus.result); end
        checks++; if (bus.resultValid !== 1'b0) begin errors++; $display("FAIL rst_rv got %b want 0", bus.resultValid); end
        resetN = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_program();
        logic [16:0] e;
        logic [7:0]  r;
        int nd;
        set_main_prog();
        load_prog(5);
        bus.progLen = 5'd5;
        exp_func.delete(); exp_res.delete();
        for (int i = 0; i < 5; i++) exp_func.push_back(prog[i]);
        exp_res.push_back(8'd9);
        start_run(12, -1);
        checks++; if (o_busy[0] !== 1'b1) begin errors++; $display("FAIL prog_busy0 got %b want 1", o_busy[0]); end
        for (int k = 1; k <= 5; k++) begin
            e = exp_func.pop_front();
            checks++; if (o_func[k] !== e[8:0]) begin errors++; $display("FAIL prog_func edge %0d got %b want %b", k, o_func[k], e[8:0]); end
            checks++; if (o_din[k] !== e[16:9]) begin errors++; $display("FAIL prog_din edge %0d got %0d want %0d", k, o_din[k], e[16:9]); end
        end
        for (int k = 6; k <= 12; k++) begin
            checks++; if (o_func[k] !== IDLE_F) begin errors++; $display("FAIL prog_idle edge %0d got %b", k, o_func[k]); end
        end
        for (int k = 0; k <= 12; k++) if (o_rv[k] === 1'b1) begin
            checks++;
            if (exp_res.size() == 0) begin errors++; $display("FAIL prog_res_extra edge %0d got %0d want none", k, o_res[k]); end
            else begin
                r = exp_res.pop_front();
                if (o_res[k] !== r) begin errors++; $display("FAIL prog_res edge %0d got %0d want %0d", k, o_res[k], r); end
            end
        end
        checks++; if (exp_res.size() != 0) begin errors++; $display("FAIL prog_res_missing left %0d want 0", exp_res.size()); end
        checks++; if (o_rv[7] !== 1'b1) begin errors++; $display("FAIL prog_rv_edge7 got %b want 1", o_rv[7]); end
        nd = 0; for (int k = 0; k <= 12; k++) if (o_done[k] === 1'b1) nd++;
        checks++; if (nd != 1) begin errors++; $display("FAIL prog_done_count got %0d want 1", nd); end
        checks++; if (o_done[8] !== 1'b1) begin errors++; $display("FAIL prog_done_edge8 got %b want 1", o_done[8]); end
        checks++; if (o_busy[8] !== 1'b1 || o_busy[9] !== 1'b0) begin errors++; $display("FAIL prog_busy_end got %b%b want 10", o_busy[8], o_busy[9]); end
    endtask

    task automatic test_len_zero();
        int bad;
        bus.progLen = 5'd0;
        start_run(6, -1);
        checks++; if (o_done[0] !== 1'b1) begin errors++; $display("FAIL len0_done got %b want 1", o_done[0]); end
        checks++; if (o_busy[0] !== 1'b1 || o_busy[1] !== 1'b0) begin errors++; $display("FAIL len0_busy got %b%b want 10", o_busy[0], o_busy[1]); end
        bad = 0;
        for (int k = 0; k <= 6; k++) if (o_func[k] !== IDLE_F || o_rv[k] !== 1'b0 || (k > 0 && o_done[k] !== 1'b0)) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL len0_quiet got %0d bad cycles want 0", bad); end
    endtask

    task automatic test_overlen();
        logic [16:0] e;
        int nd, bad;
        for (int i = 0; i < 15; i++) prog[i] = {8'(i * 3), 3'b000, 3'(i), 3'b000};
        prog[15] = {8'd0, 9'b111_111_000};
        load_prog(16);
        bus.progLen = 5'd20;
        exp_func.delete(); exp_res.delete();
        for (int i = 0; i < 16; i++) exp_func.push_back(prog[i]);
        exp_res.push_back(8'd21);
        start_run(22, -1);
        bad = 0;
        for (int k = 1; k <= 16; k++) begin
            e = exp_func.pop_front();
            if (o_func[k] !== e[8:0] || o_din[k] !== e[16:9]) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL over_issue got %0d wrong words want 0", bad); end
        checks++; if (o_func[17] !== IDLE_F) begin errors++; $display("FAIL over_stop got %b want %b", o_func[17], IDLE_F); end
        checks++; if (o_rv[18] !== 1'b1 || o_res[18] !== exp_res[0]) begin errors++; $display("FAIL over_res got %b/%0d want 1/%0d", o_rv[18], o_res[18], exp_res[0]); end
        nd = 0; for (int k = 0; k <= 22; k++) if (o_done[k] === 1'b1) nd++;
        checks++; if (nd != 1 || o_done[19] !== 1'b1) begin errors++; $display("FAIL over_done got count %0d edge19 %b want 1 1", nd, o_done[19]); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] r;
        int nrv;
        prog[0] = {8'd5, 9'b000_000_000};
        prog[1] = {8'd4, 9'b000_001_000};
        prog[2] = {8'd0, 9'b111_000_000};
        prog[3] = {8'd0, 9'b111_001_000};
        load_prog(4);
        bus.progLen = 5'd4;
        exp_res.delete();
        exp_res.push_back(8'd5); exp_res.push_back(8'd4);
        start_run(10, -1);
        checks++; if (o_rv[5] !== 1'b1 || o_rv[6] !== 1'b1) begin errors++; $display("FAIL b2b_rv got %b%b want 11", o_rv[5], o_rv[6]); end
        nrv = 0;
        for (int k = 0; k <= 10; k++) if (o_rv[k] === 1'b1) begin
            nrv++;
            checks++;
            if (exp_res.size() == 0) begin errors++; $display("FAIL b2b_res_extra edge %0d got %0d want none", k, o_res[k]); end
            else begin
                r = exp_res.pop_front();
                if (o_res[k] !== r) begin errors++; $display("FAIL b2b_res edge %0d got %0d want %0d", k, o_res[k], r); end
            end
        end
        checks++; if (nrv != 2) begin errors++; $display("FAIL b2b_count got %0d want 2", nrv); end
        checks++; if (o_done[7] !== 1'b1) begin errors++; $display("FAIL b2b_done got %b want 1", o_done[7]); end
    endtask

    task automatic test_ignored();
        logic [16:0] e;
        int nd, bad;
        set_main_prog();
        load_prog(5);
        bus.progLen = 5'd5;
        exp_func.delete();
        for (int i = 0; i < 5; i++) exp_func.push_back(prog[i]);
        start_run(14, 2);
        bad = 0;
        for (int k = 1; k <= 5; k++) begin
            e = exp_func.pop_front();
            if (o_func[k] !== e[8:0]) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL ign_funcs got %0d wrong want 0", bad); end
        nd = 0; for (int k = 0; k <= 14; k++) if (o_done[k] === 1'b1) nd++;
        checks++; if (nd != 1 || o_done[8] !== 1'b1) begin errors++; $display("FAIL ign_done got count %0d edge8 %b want 1 1", nd, o_done[8]); end
        checks++; if (o_rv[7] !== 1'b1 || o_res[7] !== 8'd9) begin errors++; $display("FAIL ign_res got %b/%0d want 1/9", o_rv[7], o_res[7]); end
        checks++; if (o_busy[14] !== 1'b0) begin errors++; $display("FAIL ign_requeued busy got %b want 0", o_busy[14]); end
        start_run(10, -1);
        checks++; if (o_func[5] !== prog[4][8:0] || o_din[5] !== prog[4][16:9]) begin errors++; $display("FAIL ign_mem got %b/%0d want %b/%0d", o_func[5], o_din[5], prog[4][8:0], prog[4][16:9]); end
        checks++; if (o_rv[7] !== 1'b1 || o_res[7] !== 8'd9) begin errors++; $display("FAIL ign_rerun_res got %b/%0d want 1/9", o_rv[7], o_res[7]); end
    endtask

    task automatic test_reset_midrun();
        int seen;
        bus.progLen = 5'd5;
        bus.start = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clock); #1;
        checks++; if (bus.func !== prog[1][8:0] || bus.busy !== 1'b1) begin errors++; $display("FAIL mid_running got %b busy %b want %b busy 1", bus.func, bus.busy, prog[1][8:0]); end
        resetN = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", bus.busy); end
        checks++; if (bus.func !== IDLE_F) begin errors++; $display("FAIL mid_func got %b want %b", bus.func, IDLE_F); end
        @(posedge clock); #1;
        resetN = 1'b1;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clock); #1;
            if (bus.done !== 1'b0 || bus.resultValid !== 1'b0 || bus.func !== IDLE_F || bus.busy !== 1'b0) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL mid_aftermath got %0d active cycles want 0", seen); end
    endtask

`ifdef SEQ_STEP_MODE_EN
    task automatic test_step();
        logic [16:0] e;
        int nd, niss, bad;
        set_main_prog();
        load_prog(5);
        bus.progLen = 5'd5;
        exp_func.delete();
        for (int i = 0; i < 5; i++) exp_func.push_back(prog[i]);
        step_period = 3;
        start_run(24, -1);
        step_period = 1;
        niss = 0; bad = 0;
        for (int k = 1; k <= 24; k++) if (o_func[k] !== IDLE_F) begin
            niss++;
            if (exp_func.size() == 0 || k % 3 != 0) bad++;
            else begin
                e = exp_func.pop_front();
                if (o_func[k] !== e[8:0] || o_din[k] !== e[16:9]) bad++;
            end
        end
        checks++; if (niss != 5 || bad != 0) begin errors++; $display("FAIL step_issue got %0d issued %0d bad want 5 0", niss, bad); end
        checks++; if (o_rv[17] !== 1'b1 || o_res[17] !== 8'd9) begin errors++; $display("FAIL step_res got %b/%0d want 1/9", o_rv[17], o_res[17]); end
        nd = 0; for (int k = 0; k <= 24; k++) if (o_done[k] === 1'b1) nd++;
        checks++; if (nd != 1 || o_done[18] !== 1'b1) begin errors++; $display("FAIL step_done got count %0d edge18 %b want 1 1", nd, o_done[18]); end
    endtask
`endif

    initial begin
        test_reset();
        test_program();
        test_len_zero();
        test_overlen();
        test_back_to_back();
        test_ignored();
        test_reset_midrun();
`ifdef SEQ_STEP_MODE_EN
        test_step();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
